// File: rtl/bullet_fire_scheduler.sv
// Fire scheduler for one player: gates shots on frame ticks via a READY/COOLDOWN/RELOAD FSM,
// allocates the lowest free bullet slot and counts hits. Optional macro: BULLET_DEFEND_RELOAD_EN.
module bullet_fire_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_AMMO        = 6,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RELOAD_FRAMES   = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 attack,
  input  logic                 defend,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_hit,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [3:0]           ammo,
  output logic                 reloading,
  output logic                 cooling,
  output logic [7:0]           hit_count,
  output logic                 hit_pulse,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } state_t;

  localparam logic [3:0] AMMO_FULL = 4'(MAX_AMMO);
  localparam logic [7:0] CD_LOAD   = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] RL_LOAD   = 8'(RELOAD_FRAMES);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           ammo_q, ammo_d;
  logic [NUM_SLOTS-1:0] launch_q, launch_d;
  logic [NUM_SLOTS-1:0] first_free;
  logic [7:0]           hit_count_q;
  logic                 hit_pulse_q;
  logic [3:0]           hit_sum;
  logic [8:0]           hit_total;
  logic                 fire_ok;
  logic                 early_rld;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    first_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        first_free    = '0;
        first_free[i] = 1'b1;
      end
    end
  end

  assign fire_ok = frame_tick && (state_q == ST_READY) && attack && !defend &&
                   (ammo_q != 4'd0) && (slot_busy != {NUM_SLOTS{1'b1}});

`ifdef BULLET_DEFEND_RELOAD_EN
  assign early_rld = frame_tick && defend && (state_q != ST_RELOAD) && (ammo_q < AMMO_FULL);
`else
  assign early_rld = 1'b0;
`endif

  // State register with the datapath registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_READY;
      cnt_q    <= 8'd0;
      ammo_q   <= AMMO_FULL;
      launch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ammo_q   <= ammo_d;
      launch_q <= launch_d;
    end
  end

  // Next-state logic; nothing moves without a frame tick, so launch self-clears next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ammo_d   = ammo_q;
    launch_d = '0;
    if (fire_ok) begin
      launch_d = first_free;
      ammo_d   = ammo_q - 4'd1;
      if (ammo_q == 4'd1) begin
        state_d = ST_RELOAD;
        cnt_d   = RL_LOAD;
      end else if (CD_LOAD == 8'd0) begin
        state_d = ST_READY;
      end else begin
        state_d = ST_COOLDOWN;
        cnt_d   = CD_LOAD;
      end
    end else if (early_rld) begin
      state_d = ST_RELOAD;
      cnt_d   = RL_LOAD;
    end else if (frame_tick) begin
      case (state_q)
        ST_COOLDOWN: begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_READY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RELOAD: begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_READY;
            cnt_d   = 8'd0;
            ammo_d  = AMMO_FULL;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output decode from the state register.
  always_comb begin
    reloading = (state_q == ST_RELOAD);
    cooling   = (state_q == ST_COOLDOWN);
    state_dbg = state_q;
  end

  // Hit collection runs every cycle, independent of frame ticks.
  always_comb begin
    hit_sum = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_sum = hit_sum + 4'(slot_hit[i]);
    end
    hit_total = {1'b0, hit_count_q} + {5'd0, hit_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q <= 8'd0;
      hit_pulse_q <= 1'b0;
    end else begin
      hit_count_q <= hit_total[8] ? 8'hFF : hit_total[7:0];
      hit_pulse_q <= |slot_hit;
    end
  end

  assign launch    = launch_q;
  assign ammo      = ammo_q;
  assign hit_count = hit_count_q;
  assign hit_pulse = hit_pulse_q;

endmodule
